// File: rtl/sisc_seq.sv
// sisc_seq: multi-cycle control sequencer for the SISC processor.
//
// A registered FSM (START, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT) steps each
// instruction through its phases. Datapath controls decode combinationally from the
// current state, the opcode and the status flags. opcode/mm/stat are not latched; the
// instruction register upstream holds them stable while the instruction is in flight.
//
// Ports
//   clk        in   system clock, rising-edge active
//   rst_f      in   synchronous active-high reset
//   opcode     in   [3:0] instruction bits [31:28]
//   mm         in   [3:0] instruction bits [27:24], branch condition mask
//   stat       in   [3:0] status flags {N,Z,C,V}
//   ir_load    out  load instruction register
//   pc_write   out  PC update enable
//   pc_sel     out  PC source: 0 = PC+1, 1 = branch target
//   br_sel     out  branch target: 0 = absolute, 1 = PC-relative
//   pc_rst     out  clear PC
//   rb_sel     out  RF read port B: 0 = ir[15:12], 1 = ir[23:20]
//   alu_op     out  [1:0] 00 reg-reg, 01 reg-imm, 10 address add
//   stat_en    out  status register load enable
//   rf_we      out  register-file write enable
//   wb_sel     out  write-back source: 0 = ALU, 1 = memory
//   dm_we      out  data-memory write enable
//   halted     out  high while in HALT
//   instr_cnt  out  [15:0] retired-instruction count, wraps

module sisc_seq (
  input  logic        clk,
  input  logic        rst_f,
  input  logic [3:0]  opcode,
  input  logic [3:0]  mm,
  input  logic [3:0]  stat,
  output logic        ir_load,
  output logic        pc_write,
  output logic        pc_sel,
  output logic        br_sel,
  output logic        pc_rst,
  output logic        rb_sel,
  output logic [1:0]  alu_op,
  output logic        stat_en,
  output logic        rf_we,
  output logic        wb_sel,
  output logic        dm_we,
  output logic        halted,
  output logic [15:0] instr_cnt
);

  localparam logic [3:0] OpNop  = 4'b0000;
  localparam logic [3:0] OpAlu  = 4'b0001;
  localparam logic [3:0] OpAluI = 4'b0010;
  localparam logic [3:0] OpLod  = 4'b0011;
  localparam logic [3:0] OpStr  = 4'b0100;
  localparam logic [3:0] OpBra  = 4'b0101;
  localparam logic [3:0] OpBrr  = 4'b0110;
  localparam logic [3:0] OpBne  = 4'b0111;
  localparam logic [3:0] OpBnr  = 4'b1000;
  localparam logic [3:0] OpHlt  = 4'b1111;

  localparam logic [1:0] AluReg  = 2'b00;
  localparam logic [1:0] AluImm  = 2'b01;
  localparam logic [1:0] AluAddr = 2'b10;

  typedef enum logic [2:0] {
    StStart,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q;
  logic        flag_hit, br_taken, br_rel, retire;

  // Branch condition: BRA/BRR take on any masked flag set, BNE/BNR on none set.
  always_comb begin
    flag_hit = |(stat & mm);
    br_taken = 1'b0;
    br_rel   = 1'b0;
    case (opcode)
      OpBra: br_taken = flag_hit;
      OpBrr: begin br_taken = flag_hit;  br_rel = 1'b1; end
      OpBne: br_taken = !flag_hit;
      OpBnr: begin br_taken = !flag_hit; br_rel = 1'b1; end
      default: ;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StStart:  state_d = StFetch;
      StFetch:  state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpHlt:                       state_d = StHalt;
          OpAlu, OpAluI, OpLod, OpStr: state_d = StExec;
          default:                     state_d = StFetch;
        endcase
      end
      StExec:   state_d = (opcode == OpLod || opcode == OpStr) ? StMem : StWb;
      StMem:    state_d = (opcode == OpStr) ? StFetch : StWb;
      StWb:     state_d = StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StStart;
    endcase
  end

  // An instruction retires when it hands control back to FETCH, or enters HALT.
  assign retire = (state_q == StDecode || state_q == StMem || state_q == StWb) &&
                  (state_d == StFetch || state_d == StHalt);

  always_ff @(posedge clk) begin
    if (rst_f) begin
      state_q <= StStart;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (retire) cnt_q <= cnt_q + 16'h0001;
    end
  end

  assign instr_cnt = cnt_q;

  // Output decode
  always_comb begin
    ir_load  = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
    pc_rst   = 1'b0;
    rb_sel   = 1'b0;
    alu_op   = AluReg;
    stat_en  = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    dm_we    = 1'b0;
    halted   = 1'b0;
    unique case (state_q)
      StStart: pc_rst = 1'b1;
      StFetch: begin
        ir_load  = 1'b1;
        pc_write = 1'b1;
      end
      StDecode: begin
        if (br_taken) begin
          pc_write = 1'b1;
          pc_sel   = 1'b1;
          br_sel   = br_rel;
        end
      end
      StExec: begin
        case (opcode)
          OpAlu:        stat_en = 1'b1;
          OpAluI:       begin alu_op = AluImm; stat_en = 1'b1; end
          OpLod, OpStr: alu_op = AluAddr;
          default: ;
        endcase
      end
      StMem: begin
        alu_op = AluAddr;
        if (opcode == OpStr) begin
          dm_we  = 1'b1;
          rb_sel = 1'b1;
        end
      end
      StWb: begin
        rf_we = 1'b1;
        // Hold the EXECUTE-phase ALU setup so the result stays valid at write-back.
        if (opcode == OpLod) begin
          wb_sel = 1'b1;
          alu_op = AluAddr;
        end else if (opcode == OpAluI) begin
          alu_op = AluImm;
        end
      end
      StHalt:  halted = 1'b1;
      default: ;
    endcase

    // Reset masks every write immediately so an interrupted instruction cannot commit.
    if (rst_f) begin
      ir_load  = 1'b0;
      pc_write = 1'b0;
      pc_sel   = 1'b0;
      br_sel   = 1'b0;
      rb_sel   = 1'b0;
      alu_op   = AluReg;
      stat_en  = 1'b0;
      rf_we    = 1'b0;
      wb_sel   = 1'b0;
      dm_we    = 1'b0;
      pc_rst   = 1'b1;
    end
  end

  logic unused_nop;
  assign unused_nop = (opcode == OpNop);

endmodule

// File: tb/tb_sisc_seq.sv
module tb_sisc_seq;

  logic        clk = 1'b0;
  logic        rst_f;
  logic [3:0]  opcode, mm, stat;
  logic        ir_load, pc_write, pc_sel, br_sel, pc_rst, rb_sel;
  logic [1:0]  alu_op;
  logic        stat_en, rf_we, wb_sel, dm_we, halted;
  logic [15:0] instr_cnt;

  int n_checks = 0;
  int n_err    = 0;

  sisc_seq dut (
    .clk       (clk),
    .rst_f     (rst_f),
    .opcode    (opcode),
    .mm        (mm),
    .stat      (stat),
    .ir_load   (ir_load),
    .pc_write  (pc_write),
    .pc_sel    (pc_sel),
    .br_sel    (br_sel),
    .pc_rst    (pc_rst),
    .rb_sel    (rb_sel),
    .alu_op    (alu_op),
    .stat_en   (stat_en),
    .rf_we     (rf_we),
    .wb_sel    (wb_sel),
    .dm_we     (dm_we),
    .halted    (halted),
    .instr_cnt (instr_cnt)
  );

  always #5 clk = ~clk;

  // Control bundle: {ir_load, pc_write, pc_sel, br_sel, pc_rst, rb_sel, alu_op[1:0],
  //                  stat_en, rf_we, wb_sel, dm_we, halted}
  logic [12:0] ctl;
  assign ctl = {ir_load, pc_write, pc_sel, br_sel, pc_rst, rb_sel, alu_op,
                stat_en, rf_we, wb_sel, dm_we, halted};

  localparam logic [12:0] CStart   = 13'b0_0_0_0_1_0_00_0_0_0_0_0;
  localparam logic [12:0] CFetch   = 13'b1_1_0_0_0_0_00_0_0_0_0_0;
  localparam logic [12:0] CIdle    = 13'b0_0_0_0_0_0_00_0_0_0_0_0;
  localparam logic [12:0] CBrAbs   = 13'b0_1_1_0_0_0_00_0_0_0_0_0;
  localparam logic [12:0] CBrRel   = 13'b0_1_1_1_0_0_00_0_0_0_0_0;
  localparam logic [12:0] CExReg   = 13'b0_0_0_0_0_0_00_1_0_0_0_0;
  localparam logic [12:0] CExImm   = 13'b0_0_0_0_0_0_01_1_0_0_0_0;
  localparam logic [12:0] CExAddr  = 13'b0_0_0_0_0_0_10_0_0_0_0_0;
  localparam logic [12:0] CMemStr  = 13'b0_0_0_0_0_1_10_0_0_0_1_0;
  localparam logic [12:0] CMemLod  = 13'b0_0_0_0_0_0_10_0_0_0_0_0;
  localparam logic [12:0] CWbReg   = 13'b0_0_0_0_0_0_00_0_1_0_0_0;
  localparam logic [12:0] CWbLod   = 13'b0_0_0_0_0_0_10_0_1_1_0_0;
  localparam logic [12:0] CHalt    = 13'b0_0_0_0_0_0_00_0_0_0_0_1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_f  = 1'b1;
    opcode = 4'b0000;
    mm     = 4'b0000;
    stat   = 4'b0000;
    tick;
    tick;
    chk("reset_ctl", {3'b0, ctl}, {3'b0, CStart});
    chk("reset_cnt", instr_cnt, 16'h0000);

    // START holds for one cycle after release; FETCH follows.
    rst_f = 1'b0;
    chk("start_ctl", {3'b0, ctl}, {3'b0, CStart});
    tick;
    chk("first_fetch", {3'b0, ctl}, {3'b0, CFetch});

    // ALU reg
    opcode = 4'b0001;
    tick; chk("alu_dec", {3'b0, ctl}, {3'b0, CIdle});
    tick; chk("alu_ex", {3'b0, ctl}, {3'b0, CExReg});
    tick; chk("alu_wb", {3'b0, ctl}, {3'b0, CWbReg});
    chk("alu_cnt_pre", instr_cnt, 16'h0000);
    tick; chk("alu_fetch", {3'b0, ctl}, {3'b0, CFetch});
    chk("alu_cnt", instr_cnt, 16'h0001);

    // LOD: five cycles FETCH to FETCH
    opcode = 4'b0011;
    tick; chk("lod_dec", {3'b0, ctl}, {3'b0, CIdle});
    tick; chk("lod_ex", {3'b0, ctl}, {3'b0, CExAddr});
    tick; chk("lod_mem", {3'b0, ctl}, {3'b0, CMemLod});
    tick; chk("lod_wb", {3'b0, ctl}, {3'b0, CWbLod});
    tick; chk("lod_fetch", {3'b0, ctl}, {3'b0, CFetch});
    chk("lod_cnt", instr_cnt, 16'h0002);

    // STR: four cycles, dm_we only in MEM
    opcode = 4'b0100;
    tick; chk("str_dec", {3'b0, ctl}, {3'b0, CIdle});
    tick; chk("str_ex", {3'b0, ctl}, {3'b0, CExAddr});
    tick; chk("str_mem", {3'b0, ctl}, {3'b0, CMemStr});
    tick; chk("str_fetch", {3'b0, ctl}, {3'b0, CFetch});
    chk("str_cnt", instr_cnt, 16'h0003);

    // BRA taken
    opcode = 4'b0101; mm = 4'b0100; stat = 4'b0100;
    tick; chk("bra_t_dec", {3'b0, ctl}, {3'b0, CBrAbs});
    tick; chk("bra_t_fetch", {3'b0, ctl}, {3'b0, CFetch});
    // BRA not taken
    stat = 4'b0000;
    tick; chk("bra_n_dec", {3'b0, ctl}, {3'b0, CIdle});
    tick; chk("bra_n_fetch", {3'b0, ctl}, {3'b0, CFetch});
    // BNR taken (no masked flag set)
    opcode = 4'b1000;
    tick; chk("bnr_t_dec", {3'b0, ctl}, {3'b0, CBrRel});
    tick;
    // BNE not taken
    opcode = 4'b0111; stat = 4'b0100;
    tick; chk("bne_n_dec", {3'b0, ctl}, {3'b0, CIdle});
    tick;
    // BRR taken on one of several masked flags
    opcode = 4'b0110; mm = 4'b0011; stat = 4'b1001;
    tick; chk("brr_t_dec", {3'b0, ctl}, {3'b0, CBrRel});
    tick; chk("br_cnt", instr_cnt, 16'h0008);

    // Undefined opcode runs as NOP in two cycles
    opcode = 4'b1010; mm = 4'b0000; stat = 4'b0000;
    tick; chk("undef_dec", {3'b0, ctl}, {3'b0, CIdle});
    tick; chk("undef_fetch", {3'b0, ctl}, {3'b0, CFetch});
    chk("undef_cnt", instr_cnt, 16'h0009);

    // ALU imm interrupted by reset in EXECUTE
    opcode = 4'b0010;
    tick;
    tick; chk("imm_ex", {3'b0, ctl}, {3'b0, CExImm});
    rst_f = 1'b1;
    #1;
    chk("rst_mask", {10'b0, pc_rst, rf_we, dm_we, stat_en, pc_write, ir_load},
        16'h0020);
    tick;
    chk("rst_mid_cnt", instr_cnt, 16'h0000);
    chk("rst_mid_rfwe", {15'b0, rf_we}, 16'h0000);
    rst_f = 1'b0;
    chk("rst_mid_start", {3'b0, ctl}, {3'b0, CStart});
    tick; chk("rst_mid_fetch", {3'b0, ctl}, {3'b0, CFetch});

    // HLT
    opcode = 4'b1111;
    tick; chk("hlt_dec", {3'b0, ctl}, {3'b0, CIdle});
    tick; chk("hlt_cnt", instr_cnt, 16'h0001);
    for (int i = 0; i < 12; i++) begin
      chk("hlt_hold", {3'b0, ctl}, {3'b0, CHalt});
      tick;
    end
    chk("hlt_cnt_hold", instr_cnt, 16'h0001);
    rst_f = 1'b1;
    tick;
    rst_f = 1'b0;
    chk("hlt_rst_start", {3'b0, ctl}, {3'b0, CStart});
    chk("hlt_rst_cnt", instr_cnt, 16'h0000);
    tick; chk("hlt_rst_fetch", {3'b0, ctl}, {3'b0, CFetch});

    // Counter wrap: 65535 NOPs then one more
    opcode = 4'b0000;
    for (int i = 0; i < 65535; i++) begin
      tick;
      tick;
    end
    chk("wrap_ffff", instr_cnt, 16'hffff);
    tick;
    tick;
    chk("wrap_zero", instr_cnt, 16'h0000);
    chk("wrap_fetch", {3'b0, ctl}, {3'b0, CFetch});

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Write enables are mutually exclusive in every cycle.
  always @(negedge clk) begin
    if (32'(rf_we) + 32'(dm_we) + 32'(stat_en) > 1) begin
      n_checks++;
      n_err++;
      $error("FAIL onehot_we observed=%b%b%b expected=at_most_one", rf_we, dm_we, stat_en);
    end
  end

endmodule
